// File: rtl/snoop_queue.sv
// In-order reservation queue: entries wait for their source operands by snooping
// the broadcast channels, and only the head entry may issue once both operands are ready.
module snoop_queue #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 5,
  parameter int OP_W    = 4,
  parameter int DEPTH   = 8,
  parameter int NBC     = 2
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     WEN,
  input  logic [OP_W-1:0]          opIn,
  input  logic [DATA_W-1:0]        dataInA,
  input  logic [DATA_W-1:0]        dataInB,
  input  logic [LABEL_W-1:0]       labelInA,
  input  logic [LABEL_W-1:0]       labelInB,
  input  logic                     requireAC,
  input  logic [NBC-1:0]           BCEN,
  input  logic [NBC*LABEL_W-1:0]   BClabel,
  input  logic [NBC*DATA_W-1:0]    BCdata,
  output logic                     require,
  output logic [OP_W-1:0]          opOut,
  output logic [DATA_W-1:0]        dataOutA,
  output logic [DATA_W-1:0]        dataOutB,
  output logic                     isFull,
  output logic                     isEmpty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [OP_W-1:0]    op_q [DEPTH];
  logic [OP_W-1:0]    op_d [DEPTH];
  logic [DATA_W-1:0]  da_q [DEPTH];
  logic [DATA_W-1:0]  da_d [DEPTH];
  logic [DATA_W-1:0]  db_q [DEPTH];
  logic [DATA_W-1:0]  db_d [DEPTH];
  logic [LABEL_W-1:0] la_q [DEPTH];
  logic [LABEL_W-1:0] la_d [DEPTH];
  logic [LABEL_W-1:0] lb_q [DEPTH];
  logic [LABEL_W-1:0] lb_d [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  // {hit, data} for a waiting label; scanning from the top lets channel 0 win ties.
  function automatic logic [DATA_W:0] snoop(input logic [LABEL_W-1:0] lbl);
    logic [DATA_W:0] r;
    r = '0;
    for (int i = NBC - 1; i >= 0; i--) begin
      if (BCEN[i] && lbl != '0 && BClabel[i*LABEL_W +: LABEL_W] == lbl)
        r = {1'b1, BCdata[i*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  logic [DATA_W:0] snp_a [DEPTH];
  logic [DATA_W:0] snp_b [DEPTH];
  logic [DATA_W:0] in_a, in_b;
  logic            pop, push;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      snp_a[e] = snoop(la_q[e]);
      snp_b[e] = snoop(lb_q[e]);
    end
    in_a = snoop(labelInA);
    in_b = snoop(labelInB);
  end

  assign isEmpty  = (count_q == '0);
  assign isFull   = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign require  = !isEmpty && valid_q[head_q] && la_q[head_q] == '0 && lb_q[head_q] == '0;
  assign opOut    = isEmpty ? '0 : op_q[head_q];
  assign dataOutA = isEmpty ? '0 : da_q[head_q];
  assign dataOutB = isEmpty ? '0 : db_q[head_q];

  assign pop  = requireAC && require;
  assign push = WEN && (!isFull || pop);

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    da_d    = da_q;
    db_d    = db_q;
    la_d    = la_q;
    lb_d    = lb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (valid_q[e] && snp_a[e][DATA_W]) begin
        da_d[e] = snp_a[e][DATA_W-1:0];
        la_d[e] = '0;
      end
      if (valid_q[e] && snp_b[e][DATA_W]) begin
        db_d[e] = snp_b[e][DATA_W-1:0];
        lb_d[e] = '0;
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    // Push after pop so a full queue can reuse the slot being freed this cycle.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = opIn;
      da_d[tail_q]    = in_a[DATA_W] ? in_a[DATA_W-1:0] : dataInA;
      la_d[tail_q]    = in_a[DATA_W] ? '0 : labelInA;
      db_d[tail_q]    = in_b[DATA_W] ? in_b[DATA_W-1:0] : dataInB;
      lb_d[tail_q]    = in_b[DATA_W] ? '0 : labelInB;
      tail_d          = tail_q + PW'(1);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        la_q[e] <= '0;
        lb_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      da_q    <= da_d;
      db_q    <= db_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end
endmodule

// File: tb/tb_snoop_queue.sv
// Directed bench for snoop_queue (DEPTH=4, NBC=2): expected issues are queued as
// entries are pushed and a negedge monitor compares every accepted head entry.
module tb_snoop_queue;
  localparam int DATA_W = 32, LABEL_W = 5, OP_W = 4, DEPTH = 4, NBC = 2;

  logic                   clk = 1'b0;
  logic                   RST, WEN, requireAC;
  logic [OP_W-1:0]        opIn;
  logic [DATA_W-1:0]      dataInA, dataInB;
  logic [LABEL_W-1:0]     labelInA, labelInB;
  logic [NBC-1:0]         BCEN;
  logic [NBC*LABEL_W-1:0] BClabel;
  logic [NBC*DATA_W-1:0]  BCdata;
  logic                   require, isFull, isEmpty;
  logic [OP_W-1:0]        opOut;
  logic [DATA_W-1:0]      dataOutA, dataOutB;
  logic [$clog2(DEPTH):0] count;

  snoop_queue #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .OP_W(OP_W), .DEPTH(DEPTH), .NBC(NBC)) dut (
    .clk(clk), .RST(RST), .WEN(WEN), .opIn(opIn), .dataInA(dataInA), .dataInB(dataInB),
    .labelInA(labelInA), .labelInB(labelInB), .requireAC(requireAC), .BCEN(BCEN),
    .BClabel(BClabel), .BCdata(BCdata), .require(require), .opOut(opOut),
    .dataOutA(dataOutA), .dataOutB(dataOutB), .isFull(isFull), .isEmpty(isEmpty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted issue must match the oldest expected entry.
  always @(negedge clk) begin
    if (!RST && require && requireAC) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected: got op=%0d a=%0d b=%0d expected none", opOut, dataOutA, dataOutB);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_op", 64'(opOut), 64'(e.op));
        chk("issue_a", 64'(dataOutA), 64'(e.a));
        chk("issue_b", 64'(dataOutB), 64'(e.b));
      end
    end
  end

  task automatic idle();
    WEN = 0; requireAC = 0; BCEN = '0; BClabel = '0; BCdata = '0; RST = 0;
    opIn = '0; dataInA = '0; dataInB = '0; labelInA = '0; labelInB = '0;
  endtask

  // Apply the currently driven inputs for one rising edge, then return to idle.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_push(input int op, input int a, input int la, input int b, input int lb);
    WEN = 1; opIn = OP_W'(op);
    dataInA = DATA_W'(a); labelInA = LABEL_W'(la);
    dataInB = DATA_W'(b); labelInB = LABEL_W'(lb);
  endtask

  task automatic set_bc(input int ch, input int lbl, input int data);
    BCEN[ch] = 1'b1;
    BClabel[ch*LABEL_W +: LABEL_W] = LABEL_W'(lbl);
    BCdata[ch*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  initial begin
    idle();
    RST = 1;
    cycle();
    chk("rst_empty", 64'(isEmpty), 1);
    chk("rst_full", 64'(isFull), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_require", 64'(require), 0);
    chk("rst_op", 64'(opOut), 0);
    chk("rst_a", 64'(dataOutA), 0);
    chk("rst_b", 64'(dataOutB), 0);

    // Ready entry issues the cycle after push.
    set_push(1, 20, 0, 7, 0); exp_q.push_back('{4'd1, 32'd20, 32'd7});
    cycle();
    chk("basic_require", 64'(require), 1);
    chk("basic_a", 64'(dataOutA), 20);
    chk("basic_count", 64'(count), 1);
    requireAC = 1;
    cycle();
    chk("basic_empty", 64'(isEmpty), 1);

    // Operand A waits on label 4 until channel 0 broadcasts it.
    set_push(2, 0, 4, 8, 0); exp_q.push_back('{4'd2, 32'd25, 32'd8});
    cycle();
    chk("wait_req0", 64'(require), 0);
    cycle();
    chk("wait_req1", 64'(require), 0);
    set_bc(0, 4, 25);
    chk("wait_req_bc", 64'(require), 0);
    cycle();
    chk("wait_req_after", 64'(require), 1);
    chk("wait_a", 64'(dataOutA), 25);
    requireAC = 1;
    cycle();

    // Enqueue bypass on channel 1; a label-0 broadcast on channel 0 must not touch B.
    set_push(3, 0, 5, 9, 0);
    set_bc(0, 0, 55);
    set_bc(1, 5, 30);
    exp_q.push_back('{4'd3, 32'd30, 32'd9});
    cycle();
    chk("bypass_require", 64'(require), 1);
    chk("bypass_a", 64'(dataOutA), 30);
    requireAC = 1;
    cycle();

    // Fill, drop while full, push with pop, drain across the pointer wrap.
    for (int i = 1; i <= 4; i++) begin
      set_push(4, i, 0, 0, 0); exp_q.push_back('{4'd4, DATA_W'(i), 32'd0});
      cycle();
    end
    chk("full_flag", 64'(isFull), 1);
    chk("full_count", 64'(count), 4);
    set_push(4, 99, 0, 0, 0);
    cycle();
    chk("drop_count", 64'(count), 4);
    chk("drop_head", 64'(dataOutA), 1);
    set_push(4, 5, 0, 0, 0); requireAC = 1; exp_q.push_back('{4'd4, 32'd5, 32'd0});
    cycle();
    chk("pushpop_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      requireAC = 1;
      cycle();
    end
    chk("drain_empty", 64'(isEmpty), 1);

    // Both channels broadcast the same label: channel 0 wins.
    set_push(5, 0, 6, 1, 0); exp_q.push_back('{4'd5, 32'd7, 32'd1});
    cycle();
    set_bc(0, 6, 7);
    set_bc(1, 6, 9);
    cycle();
    chk("prio_a", 64'(dataOutA), 7);
    requireAC = 1;
    cycle();

    // Blocked head holds back a ready younger entry; requireAC alone is ignored.
    set_push(6, 0, 3, 2, 0); exp_q.push_back('{4'd6, 32'd11, 32'd2});
    cycle();
    set_push(7, 12, 0, 13, 0); exp_q.push_back('{4'd7, 32'd12, 32'd13});
    cycle();
    chk("order_req0", 64'(require), 0);
    requireAC = 1;
    cycle();
    chk("order_count", 64'(count), 2);
    set_bc(0, 3, 11);
    cycle();
    chk("order_req1", 64'(require), 1);
    chk("order_a", 64'(dataOutA), 11);
    requireAC = 1;
    cycle();
    requireAC = 1;
    cycle();
    chk("order_empty", 64'(isEmpty), 1);

    // Mid-operation reset discards entries even with a pending pop and snoop.
    for (int i = 0; i < 3; i++) begin
      set_push(8, 40 + i, 0, 0, 0);
      cycle();
    end
    chk("pre_rst_count", 64'(count), 3);
    RST = 1; requireAC = 1; set_push(9, 0, 2, 0, 0); set_bc(0, 2, 77);
    cycle();
    chk("mid_rst_empty", 64'(isEmpty), 1);
    chk("mid_rst_require", 64'(require), 0);
    chk("mid_rst_count", 64'(count), 0);
    cycle();
    chk("exp_all_issued", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snoop_queue.md
SNOOP_QUEUE -- requirements
Module: snoop_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand data width.
REQ-002 SHALL have parameter LABEL_W, default 5, reservation tag width; tag 0 means "operand ready".
REQ-003 SHALL have parameter OP_W, default 4, opcode width.
REQ-004 SHALL have parameter DEPTH, default 8, entry count; power of two, minimum 2.
REQ-005 SHALL have parameter NBC, default 2, number of broadcast (CDB) channels, minimum 1.
REQ-006 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: WEN  in  1  enqueue request; opIn  in  OP_W; dataInA, dataInB  in  DATA_W; labelInA, labelInB  in  LABEL_W.
REQ-009 SHALL have ports: requireAC  in  1  consumer accepts head entry.
REQ-010 SHALL have ports: BCEN  in  NBC  per-channel broadcast valid; BClabel  in  NBC*LABEL_W; BCdata  in  NBC*DATA_W. Channel i occupies bits [i*W +: W].
REQ-011 SHALL have ports: require  out  1  head entry valid with both operands ready; opOut  out  OP_W; dataOutA, dataOutB  out  DATA_W.
REQ-012 SHALL have ports: isFull, isEmpty  out  1; count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-013 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH; each entry holds valid, op, two data/label pairs.
REQ-014 Pop SHALL occur when requireAC && require; requireAC with require=0 SHALL be ignored.
REQ-015 Push SHALL occur when WEN && (!isFull || pop this cycle); WEN while full without pop SHALL be dropped with no state change.
REQ-016 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-017 Issue SHALL be strictly in order: a non-ready head blocks all younger entries even if they are ready.
REQ-018 require, opOut, dataOutA, dataOutB SHALL be combinational from the head entry (zero-latency read); when isEmpty=1 opOut/dataOut SHALL be 0 and require 0.
REQ-019 Snoop: each cycle, for every valid entry operand with label != 0 and any channel i with BCEN[i]=1 and BClabel[i]==label, data SHALL load BCdata[i] and label SHALL clear to 0 at the clock edge.
REQ-020 Broadcast with BClabel==0 SHALL be ignored.
REQ-021 If several channels match the same label in one cycle, the lowest channel index SHALL win.
REQ-022 Enqueue bypass: an incoming operand whose nonzero label matches an active broadcast in the same cycle SHALL be stored already ready with that broadcast data (REQ-021 priority applies).
REQ-023 Snooped readiness SHALL be visible on require one cycle after the broadcast cycle.
REQ-024 An entry popped in the same cycle as a matching broadcast SHALL be removed; broadcast has no other effect.
REQ-025 isFull SHALL equal (count==DEPTH); isEmpty SHALL equal (count==0); both registered-derived, no combinational path from WEN.

Reset
REQ-026 RST=1 at a clock edge SHALL clear pointers, count, and all entry valid bits and labels; RST SHALL take priority over WEN, requireAC and BCEN in that cycle.
REQ-027 After reset: isEmpty=1, isFull=0, count=0, require=0, opOut=0, dataOutA=dataOutB=0.
REQ-028 Reset mid-operation SHALL discard all entries; no pop or snoop update from that cycle SHALL survive.

Verification (DEPTH=4, NBC=2)
REQ-029 Reset; push op=1, A=20/label 0, B=7/label 0 -> next cycle require=1, dataOutA=20, count=1; requireAC=1 -> next cycle isEmpty=1.
REQ-030 Push A label 4, B ready; two cycles later BCEN=01, BClabel[0]=4, BCdata[0]=25 -> require=0 until cycle after broadcast, then require=1, dataOutA=25.
REQ-031 Push A label 5 while BCEN=10, BClabel[1]=5, BCdata[1]=30 same cycle -> next cycle require=1, dataOutA=30.
REQ-032 Push 4 ready entries (A=1..4) -> isFull=1; 5th WEN dropped; push A=5 with pop -> count=4; drain yields 2,3,4,5 (pointer wrap).
REQ-033 Entry waiting on label 6; both channels broadcast label 6 with data 7 (ch0) and 9 (ch1) -> dataOutA=7.
REQ-034 Head waits on label 3, second entry ready -> require=0; broadcast label 3 data 11 -> head issues with 11, then second; assert RST with count=3 -> next cycle isEmpty=1, require=0.
